// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port memory between an instruction-fetch
// requester and a data requester, data-first with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fetch_req_i,
    input  logic [7:0] fetch_addr_i,
    output logic       fetch_gnt_o,
    output logic       fetch_valid_o,
    output logic [7:0] fetch_data_o,
    input  logic       data_req_i,
    input  logic       data_we_i,
    input  logic [7:0] data_addr_i,
    input  logic [7:0] data_wdata_i,
    output logic       data_gnt_o,
    output logic       data_valid_o,
    output logic [7:0] data_rdata_o,
    output logic [7:0] mem_addr_o,
    output logic       mem_we_o,
    output logic [7:0] mem_wdata_o,
    input  logic [7:0] mem_rdata_i,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic       data_win_q, data_win_d;
    logic       mem_we_q, mem_we_d;
    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic [7:0] fetch_data_q, fetch_data_d;
    logic [7:0] data_rdata_q, data_rdata_d;
    logic       arb;
    logic       fetch_win;

    assign arb       = (state_q == IDLE || state_q == DONE) && (fetch_req_i || data_req_i);
    assign fetch_win = fetch_req_i && (!data_req_i || starve_cnt_q == LIMIT);

    always_comb begin
        state_d      = arb ? ACCESS : state_q == ACCESS ? WAIT : state_q == WAIT ? DONE : IDLE;
        data_win_d   = data_win_q;
        mem_we_d     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        if (arb) begin
            data_win_d   = !fetch_win;
            mem_addr_d   = fetch_win ? fetch_addr_i : data_addr_i;
            mem_we_d     = !fetch_win && data_we_i;
            mem_wdata_d  = (!fetch_win && data_we_i) ? data_wdata_i : mem_wdata_q;
            starve_cnt_d = fetch_win ? 3'd0 :
                           (fetch_req_i && starve_cnt_q != LIMIT) ? starve_cnt_q + 3'd1 : starve_cnt_q;
        end
        // synchronous memory: read word is on mem_rdata_i during WAIT
        if (state_q == WAIT) begin
            fetch_data_d = data_win_q ? fetch_data_q : mem_rdata_i;
            data_rdata_d = data_win_q ? mem_rdata_i : data_rdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            data_win_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            starve_cnt_q <= 3'd0;
            mem_addr_q   <= 8'h00;
            mem_wdata_q  <= 8'h00;
            fetch_data_q <= 8'h00;
            data_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            data_win_q   <= data_win_d;
            mem_we_q     <= mem_we_d;
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign fetch_gnt_o   = state_q == ACCESS && !data_win_q;
    assign data_gnt_o    = state_q == ACCESS && data_win_q;
    assign fetch_valid_o = state_q == DONE && !data_win_q;
    assign data_valid_o  = state_q == DONE && data_win_q;
    assign fetch_data_o  = fetch_data_q;
    assign data_rdata_o  = data_rdata_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_we_o      = mem_we_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a synchronous memory model.
module tb_mem_port_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       fetch_req_i = 1'b0;
    logic [7:0] fetch_addr_i = 8'h00;
    logic       fetch_gnt_o, fetch_valid_o;
    logic [7:0] fetch_data_o;
    logic       data_req_i = 1'b0;
    logic       data_we_i = 1'b0;
    logic [7:0] data_addr_i = 8'h00;
    logic [7:0] data_wdata_i = 8'h00;
    logic       data_gnt_o, data_valid_o;
    logic [7:0] data_rdata_o;
    logic [7:0] mem_addr_o;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i = 8'h00;
    logic       busy_o;

    mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_gnt_o(fetch_gnt_o), .fetch_valid_o(fetch_valid_o), .fetch_data_o(fetch_data_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_valid_o(data_valid_o),
        .data_rdata_o(data_rdata_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o];
    end

    typedef struct {
        bit         is_d;
        logic [7:0] d;
        bit         chk_d;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   gk[$];
    int   gc[$];
    int   sc[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    bit   hold_f = 0;
    bit   hold_d = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pop_valid(input bit is_d, input logic [7:0] obs);
        exp_t e;
        chk(is_d ? "data_valid_pending" : "fetch_valid_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(is_d ? "data_valid_owner" : "fetch_valid_owner", 32'(e.is_d), 32'(is_d));
            chk(is_d ? "data_valid_latency" : "fetch_valid_latency", cyc, e.due);
            if (e.chk_d) chk(is_d ? "data_rdata" : "fetch_data", 32'(obs), 32'(e.d));
        end
    endtask

    // advance one cycle, sample #1 after the edge, act as the two requesters and score outputs
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        if (mem_we_o) we_cnt++;
        if (fetch_gnt_o && data_gnt_o) chk("gnt_onehot", 32'({fetch_gnt_o, data_gnt_o}), 32'b01);
        if (fetch_valid_o) pop_valid(0, fetch_data_o);
        if (data_valid_o) pop_valid(1, data_rdata_o);
        if (fetch_gnt_o) begin
            chk("fetch_gnt_addr", 32'(mem_addr_o), 32'(fetch_addr_i));
            chk("fetch_gnt_we", 32'(mem_we_o), 0);
            sb.push_back('{0, ref_mem[fetch_addr_i], 1, cyc + 2});
            gk.push_back(0); gc.push_back(cyc); sc.push_back(int'(dut.starve_cnt_q));
            if (!hold_f) fetch_req_i = 0;
        end
        if (data_gnt_o) begin
            chk("data_gnt_addr", 32'(mem_addr_o), 32'(data_addr_i));
            chk("data_gnt_we", 32'(mem_we_o), 32'(data_we_i));
            if (data_we_i) begin
                chk("data_gnt_wdata", 32'(mem_wdata_o), 32'(data_wdata_i));
                ref_mem[data_addr_i] = data_wdata_i;
                sb.push_back('{1, 8'h00, 0, cyc + 2});
            end else sb.push_back('{1, ref_mem[data_addr_i], 1, cyc + 2});
            gk.push_back(1); gc.push_back(cyc); sc.push_back(int'(dut.starve_cnt_q));
            if (!hold_d) data_req_i = 0;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((busy_o || fetch_req_i || data_req_i || sb.size() > 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk("drain_timeout_busy", 32'(busy_o), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, 32'({fetch_gnt_o, data_gnt_o, fetch_valid_o, data_valid_o, mem_we_o, busy_o}), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata_o), 0);
        chk({tag, "_rdata"}, 32'({fetch_data_o, data_rdata_o}), 0);
        chk({tag, "_starve"}, 32'(dut.starve_cnt_q), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 13 + 7);
            ref_mem[i] = 8'(i * 13 + 7);
        end
        mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        mem[8'h30] = 8'h5E; ref_mem[8'h30] = 8'h5E;

        // reset state
        step(); step();
        chk_all_zero("reset");
        rst_i = 0;

        // fetch-only read of 0x10; address change in flight must not matter
        fetch_addr_i = 8'h10; fetch_req_i = 1;
        step();
        chk("t1_fetch_gnt", 32'(fetch_gnt_o), 1);
        chk("t1_mem_addr", 32'(mem_addr_o), 32'h10);
        chk("t1_busy_c1", 32'(busy_o), 1);
        fetch_addr_i = 8'h55;
        step();
        chk("t1_busy_c2", 32'(busy_o), 1);
        chk("t1_no_valid_c2", 32'(fetch_valid_o), 0);
        step();
        chk("t1_fetch_valid_c3", 32'(fetch_valid_o), 1);
        chk("t1_fetch_data_c3", 32'(fetch_data_o), 32'hA5);
        chk("t1_data_valid_c3", 32'(data_valid_o), 0);
        step();
        chk("t1_busy_c4", 32'(busy_o), 0);
        chk("t1_fetch_data_hold", 32'(fetch_data_o), 32'hA5);

        // simultaneous fetch and data read: data first, fetch three cycles later
        gk.delete(); gc.delete(); sc.delete();
        fetch_addr_i = 8'h44; data_addr_i = 8'h30; data_we_i = 0;
        fetch_req_i = 1; data_req_i = 1;
        drain(40);
        chk("t2_gnt_count", gk.size(), 2);
        if (gk.size() == 2) begin
            chk("t2_first_data", gk[0], 1);
            chk("t2_second_fetch", gk[1], 0);
            chk("t2_gnt_gap", gc[1] - gc[0], 3);
        end
        chk("t2_data_rdata", 32'(data_rdata_o), 32'h5E);

        // write 0x3C to 0x20 then read it back
        we_cnt = 0;
        data_addr_i = 8'h20; data_wdata_i = 8'h3C; data_we_i = 1; data_req_i = 1;
        drain(20);
        chk("t3_we_cycles", we_cnt, 1);
        data_we_i = 0; data_wdata_i = 8'hFF; data_req_i = 1;
        drain(20);
        chk("t3_readback", 32'(data_rdata_o), 32'h3C);
        chk("t3_we_total", we_cnt, 1);

        // both held high: starvation guard forces every fourth grant to fetch
        gk.delete(); gc.delete(); sc.delete();
        hold_f = 1; hold_d = 1;
        fetch_addr_i = 8'h44; data_addr_i = 8'h30;
        fetch_req_i = 1; data_req_i = 1;
        for (int n = 0; n < 40 && gk.size() < 8; n++) step();
        fetch_req_i = 0; data_req_i = 0; hold_f = 0; hold_d = 0;
        drain(20);
        chk("t4_gnt_count", gk.size(), 8);
        for (int i = 0; i < 8 && i < gk.size(); i++) begin
            chk($sformatf("t4_gnt_kind_%0d", i), gk[i], (i % 4 == 3) ? 0 : 1);
            chk($sformatf("t4_starve_%0d", i), sc[i], (i % 4 == 3) ? 0 : (i % 4) + 1);
        end

        // reset during WAIT of a fetch aborts it
        fetch_addr_i = 8'h12; fetch_req_i = 1;
        step();
        chk("t5_fetch_gnt", 32'(fetch_gnt_o), 1);
        step();
        chk("t5_in_wait_busy", 32'(busy_o), 1);
        rst_i = 1;
        #1;
        chk_all_zero("t5_async_reset");
        sb.delete();
        step();
        chk_all_zero("t5_reset_held");
        fetch_req_i = 1;
        rst_i = 0;
        step();
        chk("t5_first_arb_gnt", 32'(fetch_gnt_o), 1);
        drain(20);
        chk("t5_refetch_data", 32'(fetch_data_o), 32'(ref_mem[8'h12]));
        chk("t5_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, legal 1..7; the number of consecutive fetch losses before fetch is forced to win.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fetch_req  input  1  instruction-fetch access request (level).
REQ-005 fetch_addr  input  8  fetch address.
REQ-006 fetch_gnt  output  1  one-cycle pulse: fetch access accepted.
REQ-007 fetch_valid  output  1  one-cycle pulse: fetch_data holds returned word.
REQ-008 fetch_data  output  8  registered fetch read data.
REQ-009 data_req  input  1  MEM-stage access request (level).
REQ-010 data_we  input  1  1 = write, 0 = read; qualifies data_req.
REQ-011 data_addr  input  8  data address.
REQ-012 data_wdata  input  8  data write value.
REQ-013 data_gnt  output  1  one-cycle pulse: data access accepted.
REQ-014 data_valid  output  1  one-cycle pulse: read data ready, or write acknowledged.
REQ-015 data_rdata  output  8  registered data read value.
REQ-016 mem_addr  output  8  registered address to the single-port memory.
REQ-017 mem_we  output  1  registered write enable to the memory.
REQ-018 mem_wdata  output  8  registered write data to the memory.
REQ-019 mem_rdata  input  8  memory read data, valid one cycle after the address edge (synchronous memory).
REQ-020 busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE; transitions ACCESS->WAIT->DONE are unconditional.
REQ-022 Arbitration SHALL occur only at edges leaving IDLE or DONE; with no request pending, the FSM SHALL go to (or stay in) IDLE.
REQ-023 On an arbitration edge with a request pending, the FSM SHALL enter ACCESS and register the winner's address, plus mem_we/mem_wdata for data writes; the winner's gnt SHALL be high for exactly that ACCESS cycle.
REQ-024 mem_we SHALL be high only during ACCESS of a data write; it SHALL be 0 in all other states.
REQ-025 At the edge leaving WAIT, mem_rdata SHALL be captured into the winner's data register, and the winner's valid SHALL be high for exactly the DONE cycle.
REQ-026 Latency: gnt in cycle N+1 and valid in cycle N+3, where N is the arbitration cycle; back-to-back throughput is one access per 3 cycles (DONE->ACCESS direct).
REQ-027 For writes, data_valid SHALL pulse in DONE as acknowledgement, and data_rdata SHALL update with mem_rdata as for reads.
REQ-028 Priority: data over fetch, except when starve_cnt == STARVE_LIMIT, in which case fetch SHALL win.
REQ-029 starve_cnt (3-bit) update rules:
- increments, saturating at STARVE_LIMIT, on each arbitration edge where fetch_req = 1 and data wins;
- clears on every fetch grant;
- otherwise holds.
REQ-030 Request level handling:
- Requesters hold req until they see gnt.
- A req still high in DONE SHALL be treated as a new request.
- The losing requester's req SHALL remain pending, with no loss or duplication.
REQ-031 fetch_data/data_rdata SHALL hold their value between captures; the non-winner's valid SHALL stay 0.
REQ-032 Input changes outside arbitration edges (addr, wdata, we) SHALL NOT affect the access in flight.

Reset
REQ-033 reset SHALL immediately force:
- state IDLE;
- fetch_gnt, data_gnt, fetch_valid, data_valid, mem_we, busy = 0;
- mem_addr, mem_wdata, fetch_data, data_rdata = 0x00;
- starve_cnt = 0.
REQ-034 Reset during ACCESS/WAIT/DONE SHALL abort the access; no valid SHALL be issued for it after release, and the write strobe SHALL drop within the reset cycle.
REQ-035 The first arbitration after release SHALL occur at the first rising edge with reset low.

Verification
REQ-036 Fetch-only read, fetch_addr 0x10, mem[0x10] = 0xA5 -> fetch_gnt in cycle 1, mem_addr = 0x10, fetch_valid in cycle 3 with fetch_data = 0xA5, busy high for cycles 1-3.
REQ-037 fetch_req and data_req (read 0x30) both rise together -> data_gnt first, fetch_gnt 3 cycles later; each valid carries the correct word.
REQ-038 data_req and fetch_req held high continuously, STARVE_LIMIT = 3 -> grant sequence D,D,D,F,D,D,D,F; starve_cnt reaches 3 and then clears.
REQ-039 Data write addr 0x20, wdata 0x3C, followed by a data read of 0x20 -> mem_we high exactly one cycle, data_valid ack, and the read returns data_rdata = 0x3C.
REQ-040 reset pulsed during WAIT of a fetch -> all outputs 0 within the same cycle, no fetch_valid afterwards, and a re-request after release is served with normal latency.
